// File: rtl/imem_dbg_ahb_slave.sv
// AHB-Lite debug responder that turns single bus transfers into accesses on the
// instruction-memory RAM port (32-bit, single-port, 1-cycle read latency).
module imem_dbg_ahb_slave #(
    parameter int unsigned HADDR_W = 16,
    parameter int unsigned RAM_AW  = 12
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               HSEL,
    input  logic [HADDR_W-1:0] HADDR,
    input  logic [1:0]         HTRANS,
    input  logic               HWRITE,
    input  logic [2:0]         HSIZE,
    input  logic [2:0]         HBURST,
    input  logic [3:0]         HPROT,
    input  logic               HMASTLOCK,
    input  logic               HREADY,
    input  logic [31:0]        HWDATA,
    output logic [31:0]        HRDATA,
    output logic               HREADYOUT,
    output logic               HRESP,
    output logic               ram_en,
    output logic [3:0]         ram_we,
    output logic [RAM_AW-1:0]  ram_addr,
    output logic [31:0]        ram_wdata,
    input  logic [31:0]        ram_rdata
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StWdata  = 3'd1;
    localparam logic [2:0] StRstall = 3'd2;
    localparam logic [2:0] StRdata  = 3'd3;
    localparam logic [2:0] StErr1   = 3'd4;
    localparam logic [2:0] StErr2   = 3'd5;

    localparam int unsigned WinW = HADDR_W + 1;
    localparam logic [WinW-1:0] WinBytes = WinW'(4 << RAM_AW);

    logic [2:0]        state_q, state_d;
    logic [3:0]        mask_q, mask_d;
    logic [RAM_AW-1:0] addr_q, addr_d;
    logic [31:0]       hrdata_q;

    logic              can_accept;
    logic              accept;
    logic              size_err;
    logic              out_of_window;
    logic              bad;
    logic              rd_now;
    logic [3:0]        lane_mask;
    logic [RAM_AW-1:0] haddr_word;

    logic unused_ahb;
    assign unused_ahb = ^{HBURST, HPROT, HMASTLOCK};

    // Wait-state cycles never take a new address phase, even if HREADY is mis-driven.
    assign can_accept = (state_q == StIdle) || (state_q == StWdata) ||
                        (state_q == StRdata) || (state_q == StErr2);
    assign accept     = HSEL && HREADY && HTRANS[1] && can_accept;
    assign haddr_word = HADDR[RAM_AW+1:2];

    assign size_err = (HSIZE > 3'd2) ||
                      ((HSIZE == 3'd1) && HADDR[0]) ||
                      ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
    assign out_of_window = {1'b0, HADDR} >= WinBytes;
    assign bad = size_err || out_of_window;

    always_comb begin
        lane_mask = 4'b1111;
        case (HSIZE)
            3'd0:    lane_mask = 4'b0001 << HADDR[1:0];
            3'd1:    lane_mask = 4'b0011 << HADDR[1:0];
            default: lane_mask = 4'b1111;
        endcase
    end

    // A legal read accepted outside WDATA goes to the RAM in its own address phase.
    assign rd_now = accept && !bad && !HWRITE && (state_q != StWdata);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        case (state_q)
            StIdle, StRdata, StErr2, StWdata: begin
                state_d = StIdle;
                if (accept) begin
                    if (bad) begin
                        state_d = StErr1;
                    end else if (HWRITE) begin
                        state_d = StWdata;
                        mask_d  = lane_mask;
                        addr_d  = haddr_word;
                    end else if (state_q == StWdata) begin
                        state_d = StRstall;
                        addr_d  = haddr_word;
                    end else begin
                        state_d = StRdata;
                    end
                end
            end
            StRstall: state_d = StRdata;
            StErr1:   state_d = StErr2;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= StIdle;
            mask_q   <= 4'b0000;
            addr_q   <= '0;
            hrdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            if (state_q == StRdata) begin
                hrdata_q <= ram_rdata;
            end
        end
    end

    // RAM strobes are gated by resetn so a reset landing on WDATA drops the write.
    always_comb begin
        ram_en = 1'b0;
        ram_we = 4'b0000;
        if (resetn) begin
            ram_en = (state_q == StWdata) || (state_q == StRstall) || rd_now;
            ram_we = (state_q == StWdata) ? mask_q : 4'b0000;
        end
    end

    assign ram_addr  = ((state_q == StWdata) || (state_q == StRstall)) ? addr_q : haddr_word;
    assign ram_wdata = HWDATA;

    assign HREADYOUT = !resetn || !((state_q == StRstall) || (state_q == StErr1));
    assign HRESP     = resetn && ((state_q == StErr1) || (state_q == StErr2));
    assign HRDATA    = (resetn && (state_q == StRdata)) ? ram_rdata : hrdata_q;

endmodule

// File: tb/tb_imem_dbg_ahb_slave.sv
// Table-driven cycle bench for imem_dbg_ahb_slave with a behavioural 1-cycle-latency RAM.
module tb_imem_dbg_ahb_slave;

    logic        clk = 1'b0;
    logic        resetn;
    logic        hsel;
    logic [15:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        preload;

    logic [31:0] mem [0:4095];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imem_dbg_ahb_slave #(
        .HADDR_W (16),
        .RAM_AW  (12)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .HSEL      (hsel),
        .HADDR     (haddr),
        .HTRANS    (htrans),
        .HWRITE    (hwrite),
        .HSIZE     (hsize),
        .HBURST    (3'b000),
        .HPROT     (4'b0011),
        .HMASTLOCK (1'b0),
        .HREADY    (hreadyout),
        .HWDATA    (hwdata),
        .HRDATA    (hrdata),
        .HREADYOUT (hreadyout),
        .HRESP     (hresp),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always @(posedge clk) begin
        if (preload) begin
            mem[12'h000] <= 32'h11111111;
            mem[12'h001] <= 32'h22222222;
            mem[12'h002] <= 32'h33333333;
            mem[12'h080] <= 32'h12345678;
            mem[12'hFFF] <= 32'hCAFEF00D;
        end else if (ram_en) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
            if (ram_we == 4'h0) ram_rdata <= mem[ram_addr];
        end
    end

    typedef struct {
        logic        rst;
        logic        sel;
        logic [1:0]  tr;
        logic        wr;
        logic [2:0]  sz;
        logic [15:0] a;
        logic [31:0] wd;
        logic        rdy;
        logic        resp;
        logic        en;
        logic [3:0]  we;
        logic [11:0] ea;
        logic        dchk;
        logic [31:0] rd;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(input logic rst, input logic sel, input logic [1:0] tr,
                               input logic wr, input logic [2:0] sz, input logic [15:0] a,
                               input logic [31:0] wd, input logic rdy, input logic resp,
                               input logic en, input logic [3:0] we, input logic [11:0] ea,
                               input logic dchk, input logic [31:0] rd);
        vec_t t;
        t.rst = rst; t.sel = sel; t.tr = tr; t.wr = wr; t.sz = sz; t.a = a; t.wd = wd;
        t.rdy = rdy; t.resp = resp; t.en = en; t.we = we; t.ea = ea; t.dchk = dchk; t.rd = rd;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t t, input string tag);
        @(posedge clk);
        #1;
        resetn = t.rst; hsel = t.sel; htrans = t.tr; hwrite = t.wr;
        hsize = t.sz; haddr = t.a; hwdata = t.wd;
        @(negedge clk);
        chk({tag, " hreadyout"}, 32'(hreadyout), 32'(t.rdy));
        chk({tag, " hresp"}, 32'(hresp), 32'(t.resp));
        chk({tag, " ram_en"}, 32'(ram_en), 32'(t.en));
        chk({tag, " ram_we"}, 32'(ram_we), 32'(t.we));
        if (t.en) chk({tag, " ram_addr"}, 32'(ram_addr), 32'(t.ea));
        if (t.dchk) chk({tag, " hrdata"}, hrdata, t.rd);
    endtask

    localparam logic [1:0] ID = 2'd0, BZ = 2'd1, NS = 2'd2;
    localparam logic [2:0] SB = 3'd0, SH = 3'd1, SW = 3'd2;

    initial begin
        resetn = 1'b0; hsel = 1'b0; htrans = ID; hwrite = 1'b0;
        hsize = SW; haddr = 16'h0; hwdata = 32'h0; preload = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset hreadyout", 32'(hreadyout), 32'd1);
        chk("reset hresp", 32'(hresp), 32'd0);
        chk("reset hrdata", hrdata, 32'h0);
        chk("reset ram_en", 32'(ram_en), 32'd0);
        chk("reset ram_we", 32'(ram_we), 32'd0);
        preload = 1'b0;

        //           rst sel tr  wr sz  addr      wdata          rdy rsp en we    ea     dchk rdata
        vq.push_back(v(1, 1, NS, 1, SW, 16'h0100, 32'h0,         1, 0, 0, 4'h0, 12'h0,   0, 32'h0));
        vq.push_back(v(1, 1, NS, 0, SW, 16'h0100, 32'hDEADBEEF,  1, 0, 1, 4'hF, 12'h040, 0, 32'h0));
        vq.push_back(v(1, 1, ID, 0, SW, 16'h0000, 32'h0,         0, 0, 1, 4'h0, 12'h040, 0, 32'h0));
        vq.push_back(v(1, 1, ID, 0, SW, 16'h0000, 32'h0,         1, 0, 0, 4'h0, 12'h0,   1, 32'hDEADBEEF));
        vq.push_back(v(1, 1, NS, 1, SB, 16'h0103, 32'h0,         1, 0, 0, 4'h0, 12'h0,   1, 32'hDEADBEEF));
        vq.push_back(v(1, 1, NS, 0, SW, 16'h0100, 32'hA5000000,  1, 0, 1, 4'h8, 12'h040, 1, 32'hDEADBEEF));
        vq.push_back(v(1, 1, ID, 0, SW, 16'h0000, 32'h0,         0, 0, 1, 4'h0, 12'h040, 1, 32'hDEADBEEF));
        vq.push_back(v(1, 1, ID, 0, SW, 16'h0000, 32'h0,         1, 0, 0, 4'h0, 12'h0,   1, 32'hA5ADBEEF));
        vq.push_back(v(1, 1, NS, 0, SW, 16'h0000, 32'h0,         1, 0, 1, 4'h0, 12'h000, 1, 32'hA5ADBEEF));
        vq.push_back(v(1, 1, NS, 0, SW, 16'h0004, 32'h0,         1, 0, 1, 4'h0, 12'h001, 1, 32'h11111111));
        vq.push_back(v(1, 1, NS, 0, SW, 16'h0008, 32'h0,         1, 0, 1, 4'h0, 12'h002, 1, 32'h22222222));
        vq.push_back(v(1, 1, ID, 0, SW, 16'h0000, 32'h0,         1, 0, 0, 4'h0, 12'h0,   1, 32'h33333333));
        vq.push_back(v(1, 1, NS, 0, SW, 16'h4000, 32'h0,         1, 0, 0, 4'h0, 12'h0,   1, 32'h33333333));
        vq.push_back(v(1, 1, ID, 0, SW, 16'h0000, 32'h0,         0, 1, 0, 4'h0, 12'h0,   1, 32'h33333333));
        vq.push_back(v(1, 1, ID, 0, SW, 16'h0000, 32'h0,         1, 1, 0, 4'h0, 12'h0,   1, 32'h33333333));
        vq.push_back(v(1, 1, NS, 1, SH, 16'h0101, 32'h0,         1, 0, 0, 4'h0, 12'h0,   0, 32'h0));
        vq.push_back(v(1, 1, ID, 0, SW, 16'h0000, 32'h0,         0, 1, 0, 4'h0, 12'h0,   0, 32'h0));
        vq.push_back(v(1, 1, ID, 0, SW, 16'h0000, 32'h0,         1, 1, 0, 4'h0, 12'h0,   0, 32'h0));
        vq.push_back(v(1, 1, BZ, 1, SW, 16'h0000, 32'h0,         1, 0, 0, 4'h0, 12'h0,   0, 32'h0));
        vq.push_back(v(1, 1, ID, 0, SW, 16'h0000, 32'h0,         1, 0, 0, 4'h0, 12'h0,   0, 32'h0));
        vq.push_back(v(1, 0, NS, 0, SW, 16'h0004, 32'h0,         1, 0, 0, 4'h0, 12'h0,   0, 32'h0));
        vq.push_back(v(1, 1, ID, 0, SW, 16'h0000, 32'h0,         1, 0, 0, 4'h0, 12'h0,   0, 32'h0));
        vq.push_back(v(1, 1, NS, 0, SW, 16'h3FFC, 32'h0,         1, 0, 1, 4'h0, 12'hFFF, 0, 32'h0));
        vq.push_back(v(1, 1, ID, 0, SW, 16'h0000, 32'h0,         1, 0, 0, 4'h0, 12'h0,   1, 32'hCAFEF00D));
        vq.push_back(v(1, 1, NS, 0, 3'd3, 16'h0000, 32'h0,       1, 0, 0, 4'h0, 12'h0,   0, 32'h0));
        vq.push_back(v(1, 1, ID, 0, SW, 16'h0000, 32'h0,         0, 1, 0, 4'h0, 12'h0,   0, 32'h0));
        vq.push_back(v(1, 1, NS, 0, SW, 16'h0004, 32'h0,         1, 1, 1, 4'h0, 12'h001, 1, 32'hCAFEF00D));
        vq.push_back(v(1, 1, ID, 0, SW, 16'h0000, 32'h0,         1, 0, 0, 4'h0, 12'h0,   1, 32'h22222222));
        vq.push_back(v(1, 1, NS, 1, SW, 16'h0200, 32'h0,         1, 0, 0, 4'h0, 12'h0,   0, 32'h0));
        vq.push_back(v(0, 1, ID, 0, SW, 16'h0000, 32'hBAD0BAD0,  1, 0, 0, 4'h0, 12'h0,   0, 32'h0));
        vq.push_back(v(1, 1, NS, 0, SW, 16'h0200, 32'h0,         1, 0, 1, 4'h0, 12'h080, 1, 32'h0));
        vq.push_back(v(1, 1, ID, 0, SW, 16'h0000, 32'h0,         1, 0, 0, 4'h0, 12'h0,   1, 32'h12345678));

        for (int i = 0; i < vq.size(); i++) begin
            run(vq[i], $sformatf("vec%0d", i));
        end

        // Write-to-write chaining, then a read that must see both merged writes.
        run(v(1, 1, NS, 1, SW, 16'h0010, 32'h0,        1, 0, 0, 4'h0, 12'h0,   0, 32'h0), "ww0");
        run(v(1, 1, NS, 1, SH, 16'h0012, 32'hAAAA5555, 1, 0, 1, 4'hF, 12'h004, 0, 32'h0), "ww1");
        run(v(1, 1, NS, 0, SW, 16'h0010, 32'h12340000, 1, 0, 1, 4'hC, 12'h004, 0, 32'h0), "ww2");
        run(v(1, 1, ID, 0, SW, 16'h0000, 32'h0,        0, 0, 1, 4'h0, 12'h004, 0, 32'h0), "ww3");
        run(v(1, 1, ID, 0, SW, 16'h0000, 32'h0,        1, 0, 0, 4'h0, 12'h0,   1, 32'h12345555), "ww4");

        chk("mem 0x200 untouched", mem[12'h080], 32'h12345678);
        chk("mem 0x010 merged", mem[12'h004], 32'h12345555);
        chk("mem 0x100 merged", mem[12'h040], 32'hA5ADBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
